// File: rtl/cellnet_fifo.sv
// cellnet_fifo: DEPTH-entry message buffer between two 4-phase req/ack ports.
// Ports: i_clk, i_reset (async, active-high);
//   upstream   i_addr, i_dat, i_req -> o_ack;
//   downstream o_addr, o_dat, o_req <- i_ack;
//   debug      o_count, o_full, o_empty.

`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 8
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 8
`endif

module cellnet_fifo #(
   parameter int ADDRESS_SIZE = `ADDRESS_SIZE,
   parameter int DATA_SIZE    = `DATA_SIZE,
   parameter int DEPTH        = 4
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic [ADDRESS_SIZE-1:0]   i_addr,
   input  logic [DATA_SIZE-1:0]      i_dat,
   input  logic                      i_req,
   output logic                      o_ack,
   output logic [ADDRESS_SIZE-1:0]   o_addr,
   output logic [DATA_SIZE-1:0]      o_dat,
   output logic                      o_req,
   input  logic                      i_ack,
   output logic [$clog2(DEPTH):0]    o_count,
   output logic                      o_full,
   output logic                      o_empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int MW = ADDRESS_SIZE + DATA_SIZE;
   localparam logic [PW:0] C_FULL = (PW+1)'(DEPTH);

   typedef enum logic {IN_IDLE, IN_ACK} in_state_t;
   typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_REL} out_state_t;

   in_state_t         r_in_state, w_in_next;
   out_state_t        r_out_state, w_out_next;
   logic [MW-1:0]     r_mem [DEPTH];
   logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
   logic [PW:0]       r_count, w_count_nxt;
   logic              r_full, r_empty;
   logic [ADDRESS_SIZE-1:0] r_addr;
   logic [DATA_SIZE-1:0]    r_dat;
   logic              w_wr, w_pop, w_load;

   always_comb begin
      w_in_next = r_in_state;
      w_wr      = 1'b0;
      unique case (r_in_state)
         IN_IDLE: begin
            // Full leaves i_req pending; it is taken once a slot frees.
            if (i_req && !r_full) begin
               w_wr      = 1'b1;
               w_in_next = IN_ACK;
            end
         end
         IN_ACK: begin
            if (!i_req) w_in_next = IN_IDLE;
         end
      endcase
   end

   always_comb begin
      w_out_next = r_out_state;
      w_pop      = 1'b0;
      w_load     = 1'b0;
      unique case (r_out_state)
         OUT_IDLE: begin
            if (!r_empty) begin
               w_load     = 1'b1;
               w_out_next = OUT_REQ;
            end
         end
         OUT_REQ: begin
            // The presented entry stays counted until the ack edge.
            if (i_ack) begin
               w_pop      = 1'b1;
               w_out_next = OUT_REL;
            end
         end
         OUT_REL: begin
            if (!i_ack) w_out_next = OUT_IDLE;
         end
         default: w_out_next = OUT_IDLE;
      endcase
   end

   always_comb begin
      w_count_nxt = r_count + {{PW{1'b0}}, w_wr} - {{PW{1'b0}}, w_pop};
   end

   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= {i_addr, i_dat};
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_in_state  <= IN_IDLE;
         r_out_state <= OUT_IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_full      <= 1'b0;
         r_empty     <= 1'b1;
         r_addr      <= '0;
         r_dat       <= '0;
      end else begin
         r_in_state  <= w_in_next;
         r_out_state <= w_out_next;
         if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == C_FULL);
         r_empty <= (w_count_nxt == '0);
         if (w_load) {r_addr, r_dat} <= r_mem[r_rd_ptr];
      end
   end

   // Handshake outputs are pure state decodes, so reset clears them at once.
   assign o_ack   = (r_in_state == IN_ACK);
   assign o_req   = (r_out_state == OUT_REQ);
   assign o_addr  = r_addr;
   assign o_dat   = r_dat;
   assign o_count = r_count;
   assign o_full  = r_full;
   assign o_empty = r_empty;

endmodule

// File: tb/tb_cellnet_fifo.sv
// tb_cellnet_fifo: randomized and directed bench for cellnet_fifo
// against a queue-based message model.

module tb_cellnet_fifo;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int DEPTH = 4;
   localparam int CW = $clog2(DEPTH) + 1;

   typedef logic [AW+DW-1:0] msg_t;

   logic          i_clk = 1'b0;
   logic          i_reset = 1'b1;
   logic [AW-1:0] i_addr = '0;
   logic [DW-1:0] i_dat = '0;
   logic          i_req = 1'b0;
   logic          o_ack;
   logic [AW-1:0] o_addr;
   logic [DW-1:0] o_dat;
   logic          o_req;
   logic          i_ack = 1'b0;
   logic [CW-1:0] o_count;
   logic          o_full;
   logic          o_empty;

   int checks = 0;
   int errors = 0;

   msg_t tx_q[$];
   msg_t rx_q[$];

   int ds_mode = 1;
   int ds_lo = 0;
   int ds_hi = 0;
   int ds_rel = 0;
   int ds_wait = 0;
   int ds_relw = 0;

   msg_t mq[$];
   bit   m_ack = 1'b0;
   int   m_ph = 0;
   msg_t m_pres = '0;

   cellnet_fifo #(
      .ADDRESS_SIZE(AW),
      .DATA_SIZE(DW),
      .DEPTH(DEPTH)
   ) dut (
      .i_clk(i_clk),
      .i_reset(i_reset),
      .i_addr(i_addr),
      .i_dat(i_dat),
      .i_req(i_req),
      .o_ack(o_ack),
      .o_addr(o_addr),
      .o_dat(o_dat),
      .o_req(o_req),
      .i_ack(i_ack),
      .o_count(o_count),
      .o_full(o_full),
      .o_empty(o_empty)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Message-level model: a queue of held messages, the message on
   // offer downstream, and the phase of each handshake.
   initial forever begin
      @(posedge i_clk or posedge i_reset);
      if (i_reset) begin
         mq.delete();
         m_ack = 1'b0;
         m_ph = 0;
         m_pres = '0;
      end else begin
         bit wr;
         bit pop;
         wr = !m_ack && i_req && (mq.size() < DEPTH);
         pop = (m_ph == 1) && i_ack;
         case (m_ph)
            0: if (mq.size() > 0) begin
               m_ph = 1;
               m_pres = mq[0];
            end
            1: if (i_ack) m_ph = 2;
            default: if (!i_ack) m_ph = 0;
         endcase
         m_ack = m_ack ? i_req : wr;
         if (pop) void'(mq.pop_front());
         if (wr) mq.push_back({i_addr, i_dat});
      end
   end

   initial forever begin
      @(negedge i_clk);
      chk("ack", o_ack, m_ack);
      chk("req", o_req, m_ph == 1);
      chk("count", o_count, mq.size());
      chk("full", o_full, mq.size() == DEPTH);
      chk("empty", o_empty, mq.size() == 0);
      chk("addr", o_addr, m_pres[AW+DW-1:DW]);
      chk("dat", o_dat, m_pres[DW-1:0]);
   end

   // Downstream consumer: ack after ds_wait cycles, release ack
   // ds_rel cycles after o_req falls.
   initial forever begin
      @(negedge i_clk);
      if (i_reset || ds_mode == 0) begin
         i_ack = 1'b0;
         ds_wait = $urandom_range(ds_hi, ds_lo);
         ds_relw = ds_rel;
      end else if (!i_ack) begin
         if (o_req) begin
            if (ds_wait == 0) begin
               i_ack = 1'b1;
               rx_q.push_back({o_addr, o_dat});
            end else begin
               ds_wait--;
            end
         end
      end else if (!o_req) begin
         if (ds_relw == 0) begin
            i_ack = 1'b0;
            ds_wait = $urandom_range(ds_hi, ds_lo);
            ds_relw = ds_rel;
         end else begin
            ds_relw--;
         end
      end
   end

   task automatic up_raise(input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n;
      @(negedge i_clk);
      i_addr = a;
      i_dat = d;
      i_req = 1'b1;
      tx_q.push_back({a, d});
      n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while (!o_ack && n < 400);
      chk("up_ack_seen", o_ack, 1'b1);
   endtask

   task automatic up_drop();
      int n;
      i_req = 1'b0;
      i_addr = AW'($urandom);
      i_dat = DW'($urandom);
      n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while (o_ack && n < 400);
      chk("up_ack_release", o_ack, 1'b0);
   endtask

   task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d);
      up_raise(a, d);
      up_drop();
   endtask

   task automatic drain_check(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while (!(o_empty && !o_req && !i_ack && !o_ack) && n < 2000);
      chk({tag, "_drained"}, n < 2000, 1'b1);
      chk({tag, "_len"}, rx_q.size(), tx_q.size());
      foreach (tx_q[i]) begin
         if (i < rx_q.size()) chk({tag, "_order"}, rx_q[i], tx_q[i]);
      end
      tx_q.delete();
      rx_q.delete();
   endtask

   initial begin
      int low;
      int n;
      repeat (2) @(negedge i_clk);
      chk("rst_ack", o_ack, 1'b0);
      chk("rst_req", o_req, 1'b0);
      chk("rst_count", o_count, 0);
      chk("rst_empty", o_empty, 1'b1);
      chk("rst_full", o_full, 1'b0);
      chk("rst_addr", o_addr, 0);
      i_reset = 1'b0;

      // single message, ack returned one cycle after o_req
      @(negedge i_clk);
      i_addr = 8'd3;
      i_dat = 8'd5;
      i_req = 1'b1;
      tx_q.push_back({8'd3, 8'd5});
      @(negedge i_clk);
      chk("t1_ack", o_ack, 1'b1);
      chk("t1_count1", o_count, 1);
      chk("t1_req_early", o_req, 1'b0);
      i_req = 1'b0;
      i_addr = 8'hEE;
      i_dat = 8'hEE;
      @(negedge i_clk);
      chk("t1_req", o_req, 1'b1);
      chk("t1_addr", o_addr, 8'd3);
      chk("t1_dat", o_dat, 8'd5);
      chk("t1_ack_low", o_ack, 1'b0);
      @(negedge i_clk);
      chk("t1_count0", o_count, 0);
      chk("t1_empty", o_empty, 1'b1);
      drain_check("t1");

      // fill to DEPTH, fifth request must wait
      ds_mode = 0;
      for (int i = 1; i <= 4; i++) send(AW'($urandom), DW'(i));
      @(negedge i_clk);
      chk("fill_full", o_full, 1'b1);
      chk("fill_count", o_count, 4);
      fork
         send(AW'($urandom), 8'd5);
         begin
            repeat (4) @(negedge i_clk);
            chk("fill_blocked", o_ack, 1'b0);
            chk("fill_count_hold", o_count, 4);
            ds_lo = 0;
            ds_hi = 0;
            ds_mode = 1;
         end
      join
      drain_check("fill");

      // write and pop on the same edge
      ds_mode = 0;
      send(8'hA0, 8'd10);
      send(8'hA1, 8'd11);
      @(negedge i_clk);
      chk("sim_count_pre", o_count, 2);
      #1 ds_mode = 1;
      fork
         begin
            up_raise(8'hA2, 8'd12);
            up_drop();
         end
         begin
            @(negedge i_clk);
            @(negedge i_clk);
            chk("sim_count", o_count, 2);
         end
      join
      drain_check("sim");

      // 20 messages with random downstream latency
      ds_lo = 0;
      ds_hi = 5;
      for (int i = 0; i < 20; i++) begin
         send(AW'($urandom), DW'(i));
         repeat ($urandom_range(2, 0)) @(negedge i_clk);
      end
      drain_check("wrap");

      // ack held high well past the fall of o_req
      ds_mode = 0;
      ds_lo = 0;
      ds_hi = 0;
      ds_rel = 10;
      for (int i = 0; i < 3; i++) send(AW'($urandom), DW'(8'h40 + i));
      @(negedge i_clk);
      #1 ds_mode = 1;
      n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while (o_req && n < 50);
      chk("stall_req_fell", o_req, 1'b0);
      low = 1;
      while (low < 50) begin
         @(negedge i_clk);
         if (o_req) break;
         low++;
      end
      chk("stall_low_cycles", low, 12);
      drain_check("stall");
      ds_rel = 0;

      // asynchronous reset mid-handshake
      ds_mode = 0;
      send(8'h21, 8'h21);
      send(8'h22, 8'h22);
      up_raise(8'h23, 8'h23);
      chk("pre_rst_count", o_count, 3);
      chk("pre_rst_req", o_req, 1'b1);
      chk("pre_rst_ack", o_ack, 1'b1);
      #2 i_reset = 1'b1;
      #1;
      chk("arst_req", o_req, 1'b0);
      chk("arst_ack", o_ack, 1'b0);
      chk("arst_count", o_count, 0);
      chk("arst_empty", o_empty, 1'b1);
      i_req = 1'b0;
      repeat (2) @(negedge i_clk);
      i_reset = 1'b0;
      tx_q.delete();
      rx_q.delete();
      ds_mode = 1;
      send(8'h07, 8'h07);
      drain_check("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cellnet_fifo.md
Name: cellnet_fifo

Overview:
- Buffered 4-phase req/ack stage placed between cellnet_source and cellnet_sink.
- Decouples the producer from the consumer by storing up to DEPTH {address, data} messages.
- Accepts messages on its upstream port and re-issues them in order on its downstream port, with the same protocol on both sides.
- Exposes occupancy for the 7-segment/LED debug top.

Parameters:
- ADDRESS_SIZE, `ADDRESS_SIZE, width of the message address field.
- DATA_SIZE, `DATA_SIZE, width of the message data field.
- DEPTH, 4, number of storage entries; must be a power of 2 and at least 2.

Ports:
- i_clk  in  1  system clock; all logic on posedge.
- i_reset  in  1  asynchronous reset, active-high.
- i_addr  in  ADDRESS_SIZE  upstream message address.
- i_dat  in  DATA_SIZE  upstream message data.
- i_req  in  1  upstream request.
- o_ack  out  1  upstream acknowledge.
- o_addr  out  ADDRESS_SIZE  downstream message address.
- o_dat  out  DATA_SIZE  downstream message data.
- o_req  out  1  downstream request.
- i_ack  in  1  downstream acknowledge.
- o_count  out  clog2(DEPTH)+1  entries currently stored.
- o_full  out  1  o_count == DEPTH.
- o_empty  out  1  o_count == 0.

Behaviour:
- Protocol on both ports is 4-phase: req rises with addr/dat stable, ack rises, req falls, ack falls.
  - Upstream addr/dat are sampled only on the edge where the entry is written.
  - o_addr/o_dat are registered and held stable for as long as o_req=1 and through the release phase.
- Reset (asynchronous, takes effect immediately):
  - o_ack=0, o_req=0, o_addr=0, o_dat=0, o_count=0, o_empty=1, o_full=0.
  - Write/read pointers = 0; both FSMs go to their idle state.
  - Stored entries are discarded.
  - Reset mid-handshake drops o_ack/o_req at once with no completion.
- Input FSM, states IN_IDLE and IN_ACK:
  - IN_IDLE: if i_req=1 and not full at edge k, write {i_addr,i_dat} at wr_ptr, increment wr_ptr, set o_ack=1 after edge k, go to IN_ACK.
  - IN_IDLE while full: o_ack stays 0 and i_req is left pending; accept on the first edge where not full.
  - IN_ACK: hold o_ack=1 until i_req=0 is sampled, then o_ack=0 and go to IN_IDLE.
  - A new request is accepted no earlier than the edge after o_ack falls.
- Output FSM, states OUT_IDLE, OUT_REQ, OUT_REL:
  - OUT_IDLE: if not empty, load o_addr/o_dat from the entry at rd_ptr, set o_req=1, go to OUT_REQ.
  - OUT_REQ: on i_ack=1, set o_req=0, increment rd_ptr (pop), go to OUT_REL.
  - OUT_REL: wait for i_ack=0, then go to OUT_IDLE.
  - An i_ack that arrives while in OUT_IDLE is ignored.
- Latency with an empty FIFO: i_req sampled high at edge k gives o_ack=1 after edge k, o_count=1 after edge k, and o_req=1 after edge k+1.
- Counting:
  - Write and pop on the same edge leave o_count unchanged.
  - Write alone: +1. Pop alone: −1.
  - o_full/o_empty are registered, derived from the next count.
  - Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
  - A write never targets an unpopped entry.
  - The entry being presented is not overwritten while o_req=1 or during OUT_REL; it is popped only on the ack edge.
- Ordering is strict FIFO with no loss and no duplication.
- Throughput: at most one message per 4-phase cycle per side; the input and output FSMs run independently.

Test Plan:
- Reset then single message: addr=3, dat=5, i_ack tied back to o_req via a 1-cycle register → o_ack rises 1 cycle after i_req; o_req rises 2 cycles after i_req with o_addr=3, o_dat=5; o_count goes 0→1→0; o_empty=1 at the end.
- Fill: i_ack held 0, push 0x1,0x2,0x3,0x4 (DEPTH=4) → o_full=1, o_count=4; a 5th i_req=1 gets o_ack held 0. Then ack one downstream message → 5th accepted; outputs appear in order 1,2,3,4,5.
- Simultaneous push/pop: with o_count=2, upstream write and downstream ack land on the same edge → o_count stays 2; data order is preserved.
- Wrap-around: stream 20 messages with dat=0..19 and a random-latency downstream ack (0–5 cycles) → all 20 received in order; pointers wrap 5 times; no protocol violations (o_addr/o_dat stable while o_req=1).
- Reset mid-operation: assert i_reset while o_req=1, o_ack=1, o_count=3 → o_req, o_ack, o_count all 0 immediately (before the next edge). After release, a new message 0x7 is delivered alone.
- Stalled release: downstream keeps i_ack=1 for 10 cycles after o_req falls while data is queued → o_req stays 0 until i_ack=0 is sampled, then the next entry is presented.
